// File: rtl/dpi_pkg.sv
// Shared types for the DPI packet sequencer.
// Stream-ID width, byte width and the sequencer FSM encoding.
package dpi_pkg;

  localparam int SID_W    = 6;
  localparam int NSTREAMS = 64;
  localparam int BYTE_W   = 8;

  typedef logic [SID_W-1:0]  sid_t;
  typedef logic [BYTE_W-1:0] char_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    STREAM,
    DRAIN,
    GAP
  } seq_state_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpi_stream_table.sv
// Per-stream seen bitmap and enable table.
// One combinational lookup port, set/clear strobes, config write port.
module dpi_stream_table
  import dpi_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  sid_t sid,
  input  logic set_seen,
  input  logic clear,
  input  logic cfg_we,
  input  sid_t cfg_sid,
  input  logic cfg_en,
  output logic seen,
  output logic en
);

  logic [NSTREAMS-1:0] seen_q;
  logic [NSTREAMS-1:0] seen_nxt;
  logic [NSTREAMS-1:0] en_q;
  logic [NSTREAMS-1:0] en_nxt;

  // A set on the same cycle as a clear survives the clear.
  always_comb begin
    seen_nxt = clear ? '0 : seen_q;
    if (set_seen) seen_nxt[sid] = 1'b1;
    en_nxt = en_q;
    if (cfg_we) en_nxt[cfg_sid] = cfg_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= '0;
      en_q   <= '0;
    end else begin
      seen_q <= seen_nxt;
      en_q   <= en_nxt;
    end
  end

  assign seen = seen_q[sid];
  assign en   = en_q[sid];

endmodule

// File: rtl/dpi_pkt_sequencer.sv
// Front-end sequencer feeding the per-regex matchers.
// Frames ingress bytes into load/stream/eop with fixed latencies.
module dpi_pkt_sequencer
  import dpi_pkg::*;
#(
  parameter int EOP_DELAY = 2,
  parameter int IPG       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_sop,
  input  logic              s_eop,
  input  logic [SID_W-1:0]  s_sid,
  input  logic              cfg_we,
  input  logic [SID_W-1:0]  cfg_sid,
  input  logic              cfg_en,
  input  logic              clear_seen,
  output logic              load_state,
  output logic              new_stream_id,
  output logic [SID_W-1:0]  stream_id,
  output logic              enable,
  output logic [BYTE_W-1:0] char_in,
  output logic              char_in_vld,
  output logic              eop,
  output logic [31:0]       pkt_count,
  output logic [15:0]       err_count,
  output logic              busy
);

  seq_state_t state;
  seq_state_t state_nxt;

  sid_t        sid_q;
  logic        en_q;
  char_t       char_q;
  logic        vld_q;
  logic [31:0] pkt_q;
  logic [15:0] err_q;
  logic        run_q;
  logic        first_q;
  logic [7:0]  since_q;
  logic [7:0]  gap_q;

  logic ready;
  logic drop;
  logic accept;
  logic bad_sop;
  logic set_seen;
  logic eop_fire;
  logic tbl_seen;
  logic tbl_en;

  dpi_stream_table u_tbl (
    .clk      (clk),
    .rst_n    (rst_n),
    .sid      (sid_q),
    .set_seen (set_seen),
    .clear    (clear_seen),
    .cfg_we   (cfg_we),
    .cfg_sid  (cfg_sid),
    .cfg_en   (cfg_en),
    .seen     (tbl_seen),
    .en       (tbl_en)
  );

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    drop      = 1'b0;
    accept    = 1'b0;
    bad_sop   = 1'b0;
    set_seen  = 1'b0;
    eop_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        // run_q keeps s_ready low while reset is held or just released
        if (run_q && s_valid) begin
          if (s_sop) begin
            state_nxt = LOAD;
          end else begin
            ready = 1'b1;
            drop  = 1'b1;
          end
        end
      end
      LOAD: begin
        set_seen  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = STREAM;
      STREAM: begin
        ready = 1'b1;
        if (s_valid) begin
          if (s_sop && !first_q) begin
            bad_sop   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            accept = 1'b1;
            if (s_eop) state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!vld_q && int'(since_q) >= EOP_DELAY) begin
          eop_fire  = 1'b1;
          state_nxt = (IPG == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (int'(gap_q) >= IPG - 1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sid_q   <= '0;
      en_q    <= 1'b0;
      char_q  <= '0;
      vld_q   <= 1'b0;
      pkt_q   <= '0;
      err_q   <= '0;
      run_q   <= 1'b0;
      first_q <= 1'b0;
      since_q <= '0;
      gap_q   <= '0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
      if (state == IDLE && state_nxt == LOAD) sid_q <= s_sid;
      if (state == LOAD) en_q <= tbl_en;
      if (accept) char_q <= s_data;
      vld_q <= accept;
      if (state == WAIT) first_q <= 1'b1;
      else if (s_valid && ready) first_q <= 1'b0;
      // cycles since char_in_vld was last high
      if (vld_q) since_q <= '0;
      else if (since_q != 8'hFF) since_q <= since_q + 8'd1;
      gap_q <= (state == GAP) ? gap_q + 8'd1 : 8'd0;
      if (eop_fire) pkt_q <= pkt_q + 32'd1;
      if (drop || bad_sop) err_q <= sat_inc16(err_q);
    end
  end

  assign s_ready       = ready;
  assign load_state    = (state == LOAD);
  assign new_stream_id = (state == LOAD) && !tbl_seen;
  assign stream_id     = sid_q;
  assign enable        = (state == LOAD) ? tbl_en : en_q;
  assign char_in       = char_q;
  assign char_in_vld   = vld_q;
  assign eop           = eop_fire;
  assign pkt_count     = pkt_q;
  assign err_count     = err_q;
  assign busy          = (state != IDLE);

endmodule
